// File: rtl/freq_meter.sv
// Gated rising-edge frequency meter: counts synchronized sig_in_i edges over GATE_CYCLES clk_int cycles.
// Optional period measurement between successive edges is built when PERIOD_MEAS_EN is defined.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 12_000_000,
    parameter int unsigned FREQ_W      = 24,
    parameter int unsigned PERIOD_W    = 25
) (
    input  logic              clk_int,
    input  logic              rst,
    input  logic              sig_in_i,
    input  logic              en_i,
    output logic [FREQ_W-1:0] freq_out_o,
    output logic              freq_valid_o,
    output logic              overflow_o,
    output logic              busy_o
`ifdef PERIOD_MEAS_EN
    ,
    output logic [PERIOD_W-1:0] period_out_o,
    output logic                period_valid_o
`endif
);

    localparam int unsigned GateW = $clog2(GATE_CYCLES);
    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2 || FREQ_W < 1 || PERIOD_W < 1) begin : g_param_check
        $error("freq_meter: GATE_CYCLES must be >= 2, FREQ_W and PERIOD_W >= 1");
    end

    typedef enum logic [0:0] {StIdle, StGate} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, sync3_q, edge_det_q;
    logic [GateW-1:0]  gate_cnt_q, gate_cnt_d;
    logic [FREQ_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
    logic              fvalid_q, fvalid_d;
    logic              edge_cnt_max;

    assign edge_cnt_max = &edge_cnt_q;

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        fvalid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en_i) state_d = StGate;
            end
            StGate: begin
                if (!en_i) begin
                    // Abort: the partial window is discarded, results hold.
                    state_d    = StIdle;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (gate_cnt_q == GateLast) begin
                    // An edge on the last gate cycle still belongs to this window.
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    freq_d     = (edge_cnt_max && edge_det_q) ? edge_cnt_q
                                                              : edge_cnt_q + FREQ_W'(edge_det_q);
                    ovf_d      = sat_q | (edge_cnt_max & edge_det_q);
                    fvalid_d   = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + GateW'(1);
                    if (edge_det_q) begin
                        if (edge_cnt_max) sat_d = 1'b1;
                        else              edge_cnt_d = edge_cnt_q + FREQ_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_int or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            edge_det_q <= 1'b0;
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            fvalid_q   <= 1'b0;
        end else begin
            sync1_q    <= sig_in_i;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            edge_det_q <= sync2_q & ~sync3_q;
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            fvalid_q   <= fvalid_d;
        end
    end

    assign freq_out_o   = freq_q;
    assign freq_valid_o = fvalid_q;
    assign overflow_o   = ovf_q;
    assign busy_o       = (state_q == StGate);

`ifdef PERIOD_MEAS_EN
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                seen_q, seen_d;
    logic                pvalid_q, pvalid_d;

    always_comb begin
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        seen_d    = seen_q;
        pvalid_d  = 1'b0;
        if (!en_i) begin
            per_cnt_d = '0;
            seen_d    = 1'b0;
        end else if (edge_det_q) begin
            if (seen_q) begin
                period_d = per_cnt_q;
                pvalid_d = 1'b1;
            end
            // Restart at 1 so the edge-to-edge distance is reported directly.
            per_cnt_d = PERIOD_W'(1);
            seen_d    = 1'b1;
        end else if (!(&per_cnt_q)) begin
            per_cnt_d = per_cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk_int or negedge rst) begin
        if (!rst) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            seen_q    <= 1'b0;
            pvalid_q  <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            seen_q    <= seen_d;
            pvalid_q  <= pvalid_d;
        end
    end

    assign period_out_o   = period_q;
    assign period_valid_o = pvalid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: table of gate windows on a 1200-cycle instance, plus
// abort, reset, saturation (4-bit instance) and, when PERIOD_MEAS_EN is defined, period checks.
module tb_freq_meter;

    localparam int G1 = 1200;
    localparam int G2 = 100;

    logic        clk_int = 1'b0;
    logic        rst;
    logic        sig1, en1, sig2, en2;
    logic [23:0] freq1;
    logic [3:0]  freq2;
    logic        fv1, ovf1, busy1, fv2, ovf2, busy2;
`ifdef PERIOD_MEAS_EN
    logic [24:0] po1;
    logic [7:0]  po2;
    logic        pv1, pv2;
`endif

    int checks = 0;
    int errors = 0;
    int per1   = 0;
    bit level1 = 1'b0;

    always #5 clk_int = ~clk_int;

    freq_meter #(.GATE_CYCLES(G1), .FREQ_W(24), .PERIOD_W(25)) dut1 (
        .clk_int      (clk_int),
        .rst          (rst),
        .sig_in_i     (sig1),
        .en_i         (en1),
        .freq_out_o   (freq1),
        .freq_valid_o (fv1),
        .overflow_o   (ovf1),
        .busy_o       (busy1)
`ifdef PERIOD_MEAS_EN
        ,
        .period_out_o   (po1),
        .period_valid_o (pv1)
`endif
    );

    freq_meter #(.GATE_CYCLES(G2), .FREQ_W(4), .PERIOD_W(8)) dut2 (
        .clk_int      (clk_int),
        .rst          (rst),
        .sig_in_i     (sig2),
        .en_i         (en2),
        .freq_out_o   (freq2),
        .freq_valid_o (fv2),
        .overflow_o   (ovf2),
        .busy_o       (busy2)
`ifdef PERIOD_MEAS_EN
        ,
        .period_out_o   (po2),
        .period_valid_o (pv2)
`endif
    );

    // Square wave of per1 cycles (high for per1/2), or a constant level when per1 == 0.
    initial begin
        int cnt = 0;
        sig1 = 1'b0;
        forever begin
            @(negedge clk_int);
            if (per1 == 0) begin
                sig1 = level1;
                cnt  = 0;
            end else begin
                cnt  = (cnt + 1 >= per1) ? 0 : cnt + 1;
                sig1 = (cnt < per1 / 2);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycles until the selected valid pulse (-1 on timeout); also reports whether busy1 stayed high.
    task automatic wait_evt(input int sel, input int max, output int n, output bit busy_ok);
        n = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk_int);
            #1;
            if (sel == 1 && !busy1) busy_ok = 1'b0;
            if ((sel == 1 && fv1) || (sel == 2 && fv2)) begin
                n = i;
                break;
            end
`ifdef PERIOD_MEAS_EN
            if (sel == 3 && pv1) begin
                n = i;
                break;
            end
`endif
        end
    endtask

    task automatic pulses2(input int count);
        for (int i = 0; i < count; i++) begin
            sig2 = 1'b1;
            repeat (2) @(negedge clk_int);
            sig2 = 1'b0;
            repeat (2) @(negedge clk_int);
        end
    endtask

    typedef struct {
        int per;
        bit level;
        int exp_freq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int fv_cnt;
        bit bok;

        vecs[0] = '{per: 12, level: 1'b0, exp_freq: 100};
        vecs[1] = '{per: 0,  level: 1'b0, exp_freq: 0};
        vecs[2] = '{per: 8,  level: 1'b0, exp_freq: 150};
        vecs[3] = '{per: 0,  level: 1'b1, exp_freq: 0};
        vecs[4] = '{per: 24, level: 1'b0, exp_freq: 50};
        vecs[5] = '{per: 2,  level: 1'b0, exp_freq: 600};

        rst  = 1'b1;
        en1  = 1'b0;
        en2  = 1'b0;
        sig2 = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk_int);
        check("reset_freq_out", freq1, 0);
        check("reset_freq_valid", fv1, 0);
        check("reset_overflow", ovf1, 0);
        check("reset_busy", busy1, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk_int);

        for (int v = 0; v < 6; v++) begin
            @(negedge clk_int);
            en1    = 1'b0;
            per1   = vecs[v].per;
            level1 = vecs[v].level;
            repeat (30) @(negedge clk_int);
            en1 = 1'b1;
            wait_evt(1, G1 + 20, n, bok);
            check($sformatf("v%0d_first_latency", v), n, G1 + 1);
            check($sformatf("v%0d_first_freq", v), freq1, vecs[v].exp_freq);
            check($sformatf("v%0d_first_ovf", v), ovf1, 0);
            check($sformatf("v%0d_first_busy", v), bok, 1);
            wait_evt(1, G1 + 20, n, bok);
            check($sformatf("v%0d_b2b_interval", v), n, G1);
            check($sformatf("v%0d_b2b_freq", v), freq1, vecs[v].exp_freq);
            check($sformatf("v%0d_b2b_busy", v), bok, 1);
        end

        // Abort at gate_cnt 600 with a different rate running, then re-arm.
        @(negedge clk_int);
        en1  = 1'b0;
        per1 = 12;
        repeat (30) @(negedge clk_int);
        en1 = 1'b1;
        wait_evt(1, G1 + 20, n, bok);
        check("abort_pre_freq", freq1, 100);
        per1 = 8;
        repeat (600) @(posedge clk_int);
        @(negedge clk_int);
        en1 = 1'b0;
        @(posedge clk_int);
        #1;
        check("abort_busy_low", busy1, 0);
        fv_cnt = 0;
        for (int i = 0; i < 1300; i++) begin
            @(posedge clk_int);
            #1;
            if (fv1) fv_cnt++;
        end
        check("abort_no_valid", fv_cnt, 0);
        check("abort_freq_hold", freq1, 100);
        @(negedge clk_int);
        en1 = 1'b1;
        wait_evt(1, G1 + 20, n, bok);
        check("rearm_latency", n, G1 + 1);
        check("rearm_freq", freq1, 150);

        // Asynchronous reset mid-window, release with en held high.
        repeat (300) @(negedge clk_int);
        per1   = 0;
        level1 = 1'b0;
        repeat (10) @(negedge clk_int);
        rst = 1'b0;
        #1;
        check("rst_mid_freq_out", freq1, 0);
        check("rst_mid_busy", busy1, 0);
        check("rst_mid_valid", fv1, 0);
        check("rst_mid_ovf", ovf1, 0);
        repeat (3) @(negedge clk_int);
        rst = 1'b1;
        wait_evt(1, G1 + 20, n, bok);
        check("rst_release_latency", n, G1 + 1);
        check("rst_release_freq", freq1, 0);

        // Saturation on the 4-bit instance, then recovery.
        @(negedge clk_int);
        en2 = 1'b1;
        pulses2(20);
        wait_evt(2, 60, n, bok);
        check("sat_valid_seen", (n > 0), 1);
        check("sat_freq", freq2, 15);
        check("sat_ovf", ovf2, 1);
        pulses2(3);
        wait_evt(2, 120, n, bok);
        check("unsat_valid_seen", (n > 0), 1);
        check("unsat_freq", freq2, 3);
        check("unsat_ovf", ovf2, 0);

`ifdef PERIOD_MEAS_EN
        @(negedge clk_int);
        en1  = 1'b0;
        per1 = 37;
        repeat (30) @(negedge clk_int);
        check("period_before_first", po1, 0);
        en1 = 1'b1;
        wait_evt(3, 120, n, bok);
        check("period_first_seen", (n > 37), 1);
        check("period_first_val", po1, 37);
        for (int k = 0; k < 4; k++) begin
            wait_evt(3, 60, n, bok);
            check($sformatf("period_interval_%0d", k), n, 37);
            check($sformatf("period_val_%0d", k), po1, 37);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
